dac_i2s_tx: RTL and testbench
=============================

// Module: dac_i2s_tx
// PURPOSE
//  Serial audio transmitter clocked by the DAC bit clock (~1536 kHz = 48 kHz * 32).
//  Accepts stereo PCM samples over a valid/ready handshake and emits an I2S / left-justified frame.
//  Frame is 2*SLOT_W bits: left slot then right slot, MSB first.
//  Sits between the audio mixer (CDC done upstream) and the board DAC pins.
// PARAMETERS
//  DATA_W    16  sample width per channel; must be <= SLOT_W
//  SLOT_W    16  bits per channel slot; frame length FRAME_LEN = 2*SLOT_W
//  I2S_MODE  1   1: data lags LRCK edge by one bit (I2S); 0: left-justified
// PORTS
//  CLK           in   1       DAC bit clock; all logic on posedge; board forwards ~CLK as BCK
//  RESET_n       in   1       asynchronous, active-low reset
//  ENABLE        in   1       run request; sampled at frame boundaries
//  SAMPLE_VALID  in   1       upstream sample pair valid
//  SAMPLE_READY  out  1       holding register can take a pair this cycle
//  SAMPLE_L      in   DATA_W  left sample, two's complement
//  SAMPLE_R      in   DATA_W  right sample, two's complement
//  DAC_LRCK      out  1       word select: 0 = left, 1 = right
//  DAC_DATA      out  1       serial data
//  FRAME_START   out  1       one-cycle pulse when frame bit 0 (left MSB) is on DAC_DATA
//  UNDERRUN      out  1       one-cycle pulse: frame loaded with holding register empty
// BEHAVIOUR
//  Reset: DAC_LRCK=0, DAC_DATA=0, SAMPLE_READY=0, FRAME_START=0, UNDERRUN=0; state IDLE; k=0; holding empty.
//  Holding reg (1 entry): SAMPLE_READY = !hold_full || load_now (combinational).
//   Accept on VALID&&READY. Accept plus load in the same cycle keeps hold_full=1 with the new pair.
//  Shifter: FRAME_LEN bits, {L,zero-pad,R,zero-pad}; each sample is left-aligned in its slot.
//  Counter k: 0..FRAME_LEN-1 in RUN; wraps FRAME_LEN-1 -> 0; held at 0 in IDLE.
//  Registered outputs: at counter k, DAC_DATA = frame bit k (bit 0 = L MSB).
//  DAC_LRCK leads data by I2S_MODE cycles:
//   - high for k in [SLOT_W-I2S_MODE, FRAME_LEN-1-I2S_MODE];
//   - low elsewhere (k=FRAME_LEN-1 counts as low when I2S_MODE=1).
//  load_now: in IDLE when ENABLE=1, or in RUN at k=FRAME_LEN-1 with ENABLE=1.
//   Shifter takes the holding reg if full and clears hold_full.
//   If empty: UNDERRUN pulses in the load cycle and the shifter takes the underrun frame (CONFIGURATION).
//  States:
//   - IDLE -> RUN on ENABLE=1, with load.
//   - RUN -> RUN at wrap while ENABLE=1.
//   - RUN -> IDLE at k=FRAME_LEN-1 if ENABLE=0; the frame in progress is always completed.
//  IDLE: DAC_DATA=0, DAC_LRCK=0; holding reg still accepts (prefill).
//  Latency: accepted pair starts at the next frame boundary; sustained throughput is 1 pair per FRAME_LEN cycles.
//  FRAME_START is asserted in the cycle DAC_DATA carries bit 0.
//  Async reset mid-frame: all outputs return to reset values immediately; holding contents are discarded.
// CONFIGURATION
//  DAC_TX_HOLD_ON_UNDERRUN_EN:
//   - defined: on underrun, retransmit the last loaded frame (zeros if none since reset).
//   - undefined: on underrun, transmit an all-zero frame.
//  UNDERRUN pulses identically in both builds.
// STRUCTURE
//  Package dac_tx_pkg: state enum (ST_IDLE, ST_RUN), FRAME_LEN function of SLOT_W, slot-packing function.
//  Sub-module dac_sample_hold: 1-entry valid/ready holding register with load/consume port.
//  Top-level holds FSM, counter, shifter, output registers.
// TESTING
//  1. Prefill L=16'h8001, R=16'h7FFE in IDLE, raise ENABLE:
//     FRAME_START, then DAC_DATA = 1000_0000_0000_0001 / 0111_1111_1111_1110;
//     LRCK edges one bit before each slot MSB.
//  2. Stream 4 pairs with VALID held high: READY pulses once per 32 cycles; no UNDERRUN; frames back-to-back.
//  3. Stop feeding after pair A=(16'h1234,16'h5678): next frame has UNDERRUN=1;
//     data = A if DAC_TX_HOLD_ON_UNDERRUN_EN is defined, else all zeros.
//  4. Drop ENABLE at k=5: frame completes through k=31, then IDLE (DATA=0, LRCK=0); a queued pair stays held.
//  5. Assert RESET_n=0 at k=20: outputs 0 asynchronously; after release, IDLE with hold empty and READY=1.
//  6. I2S_MODE=0, SLOT_W=24, DATA_W=16: LRCK aligned with MSB; bits 16..23 of each slot are 0.

Source files
------------

// File: rtl/dac_tx_pkg.sv
// Shared definitions for the DAC I2S transmitter.
//   ST_IDLE / ST_RUN : FSM state encodings
//   frame_len()      : serial frame length for a given slot width
//   pack_slot()      : left-aligns a sample inside its slot (zero padding below)
package dac_tx_pkg;

    localparam int unsigned MAX_SLOT_W = 32;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic int unsigned frame_len(input int unsigned slot_w);
        return 2 * slot_w;
    endfunction

    // Result's low slot_w bits hold the sample MSB-aligned with zeros beneath.
    function automatic logic [MAX_SLOT_W-1:0] pack_slot(
        input logic [MAX_SLOT_W-1:0] sample,
        input int unsigned           data_w,
        input int unsigned           slot_w
    );
        return sample << (slot_w - data_w);
    endfunction

endpackage

// File: rtl/dac_sample_hold.sv
// One-entry valid/ready holding register for a stereo sample pair.
//   CLK, RESET_n     : clock, async active-low reset
//   valid, data_l/r  : upstream pair
//   ready_c          : combinational ready (free slot, or being consumed this cycle)
//   consume          : downstream takes the held pair this cycle
//   full, hold_l/r   : held pair status and contents
module dac_sample_hold #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic              valid,
    input  logic [DATA_W-1:0] data_l,
    input  logic [DATA_W-1:0] data_r,
    input  logic              consume,
    output logic              ready_c,
    output logic              full,
    output logic [DATA_W-1:0] hold_l,
    output logic [DATA_W-1:0] hold_r
);

    logic accept_c;

    // Ready is forced low while reset is asserted.
    assign ready_c  = RESET_n & (~full | consume);
    assign accept_c = valid & ready_c;

    // Accept wins over consume so a simultaneous accept+consume stays full.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            full   <= 1'b0;
            hold_l <= '0;
            hold_r <= '0;
        end else if (accept_c) begin
            full   <= 1'b1;
            hold_l <= data_l;
            hold_r <= data_r;
        end else if (consume) begin
            full   <= 1'b0;
        end
    end

endmodule

// File: rtl/dac_i2s_tx.sv
// Stereo I2S / left-justified serial transmitter, clocked by the DAC bit clock.
//   CLK, RESET_n        : bit clock (posedge), async active-low reset
//   ENABLE              : run request, sampled at frame boundaries
//   SAMPLE_VALID/READY  : pair handshake (READY is combinational)
//   SAMPLE_L/R          : two's complement samples
//   DAC_LRCK, DAC_DATA  : word select and serial data (registered)
//   FRAME_START         : high while frame bit 0 (left MSB) is on DAC_DATA
//   UNDERRUN            : high during that same first bit when the frame was loaded from an empty holding register
// Build option DAC_TX_HOLD_ON_UNDERRUN_EN: on underrun repeat the last loaded frame instead of sending zeros.
module dac_i2s_tx
    import dac_tx_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned SLOT_W   = 16,
    parameter int unsigned I2S_MODE = 1
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic              ENABLE,
    input  logic              SAMPLE_VALID,
    output logic              SAMPLE_READY,
    input  logic [DATA_W-1:0] SAMPLE_L,
    input  logic [DATA_W-1:0] SAMPLE_R,
    output logic              DAC_LRCK,
    output logic              DAC_DATA,
    output logic              FRAME_START,
    output logic              UNDERRUN
);

    localparam int unsigned FRAME_LEN = frame_len(SLOT_W);
    localparam int unsigned K_W       = $clog2(FRAME_LEN);
    localparam int unsigned LRCK_LO   = SLOT_W - I2S_MODE;
    localparam int unsigned LRCK_HI   = FRAME_LEN - 1 - I2S_MODE;
    localparam logic [K_W-1:0] K_LAST = K_W'(FRAME_LEN - 1);

    logic [0:0]           state_q, state_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [FRAME_LEN-1:0] frame_q, frame_d;
    logic [FRAME_LEN-1:0] frame_hold_c;
    logic [K_W-1:0]       bit_idx_c;
    logic                 load_now_c;
    logic                 run_d_c;
    logic                 lrck_c;
    logic                 hold_full;
    logic [DATA_W-1:0]    hold_l, hold_r;

    dac_sample_hold #(.DATA_W(DATA_W)) u_hold (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .valid   (SAMPLE_VALID),
        .data_l  (SAMPLE_L),
        .data_r  (SAMPLE_R),
        .consume (load_now_c),
        .ready_c (SAMPLE_READY),
        .full    (hold_full),
        .hold_l  (hold_l),
        .hold_r  (hold_r)
    );

    // Frame held MSB-first: vector bit FRAME_LEN-1 is frame bit 0 (left MSB).
    assign frame_hold_c = {SLOT_W'(pack_slot(MAX_SLOT_W'(hold_l), DATA_W, SLOT_W)),
                           SLOT_W'(pack_slot(MAX_SLOT_W'(hold_r), DATA_W, SLOT_W))};

    // Next-state, counter and frame-load logic.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        frame_d    = frame_q;
        load_now_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                k_d = '0;
                if (ENABLE) begin
                    load_now_c = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (ENABLE) begin
                        load_now_c = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = '0;
            end
        endcase
        if (load_now_c) begin
            if (hold_full) begin
                frame_d = frame_hold_c;
            end
`ifndef DAC_TX_HOLD_ON_UNDERRUN_EN
            else begin
                frame_d = '0;
            end
`endif
        end
    end

    // Outputs are computed from next-cycle values so the registers line up with k.
    assign run_d_c   = (state_d == ST_RUN);
    assign bit_idx_c = K_LAST - k_d;
    assign lrck_c    = ({1'b0, k_d} >= (K_W+1)'(LRCK_LO)) &&
                       ({1'b0, k_d} <= (K_W+1)'(LRCK_HI));

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            frame_q     <= '0;
            DAC_DATA    <= 1'b0;
            DAC_LRCK    <= 1'b0;
            FRAME_START <= 1'b0;
            UNDERRUN    <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            frame_q     <= frame_d;
            DAC_DATA    <= run_d_c & frame_d[bit_idx_c];
            DAC_LRCK    <= run_d_c & lrck_c;
            FRAME_START <= load_now_c;
            UNDERRUN    <= load_now_c & ~hold_full;
        end
    end

endmodule

// File: tb/tb_dac_i2s_tx.sv
// Bench for dac_i2s_tx: a frame-level model checks the 16/16/I2S instance every cycle;
// directed scenarios pin literal frames; a second 16/24/left-justified instance is checked directly.
module tb_dac_i2s_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, valid = 1'b0;
    logic [15:0] sl = '0, sr = '0;
    logic        ready, lrck, data, fs, ur;

    logic        en6 = 1'b0, v6 = 1'b0;
    logic [15:0] l6 = '0, r6 = '0;
    logic        rdy6, lr6, d6, fs6, ur6;

    int n_err = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    dac_i2s_tx #(.DATA_W(16), .SLOT_W(16), .I2S_MODE(1)) dut (
        .CLK(clk), .RESET_n(rst_n), .ENABLE(en), .SAMPLE_VALID(valid), .SAMPLE_READY(ready),
        .SAMPLE_L(sl), .SAMPLE_R(sr), .DAC_LRCK(lrck), .DAC_DATA(data),
        .FRAME_START(fs), .UNDERRUN(ur)
    );

    dac_i2s_tx #(.DATA_W(16), .SLOT_W(24), .I2S_MODE(0)) dut6 (
        .CLK(clk), .RESET_n(rst_n), .ENABLE(en6), .SAMPLE_VALID(v6), .SAMPLE_READY(rdy6),
        .SAMPLE_L(l6), .SAMPLE_R(r6), .DAC_LRCK(lr6), .DAC_DATA(d6),
        .FRAME_START(fs6), .UNDERRUN(ur6)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    bit          m_run = 1'b0;
    int          m_pos = 0;
    logic [15:0] m_l = '0, m_r = '0;
    bit          m_fs = 1'b0, m_ur = 1'b0;
    logic [31:0] hq[$];

    function automatic bit at_boundary();
        return en && (!m_run || m_pos == 31);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0; m_pos = 0; m_l = '0; m_r = '0;
            m_fs = 1'b0; m_ur = 1'b0; hq.delete();
        end else begin
            bit bnd, acc;
            logic [31:0] p;
            bnd  = at_boundary();
            acc  = valid && (hq.size() == 0 || bnd);
            m_fs = 1'b0;
            m_ur = 1'b0;
            if (bnd) begin
                if (hq.size() > 0) begin
                    p = hq.pop_front();
                    m_l = p[31:16];
                    m_r = p[15:0];
                end else begin
                    m_ur = 1'b1;
`ifndef DAC_TX_HOLD_ON_UNDERRUN_EN
                    m_l = '0;
                    m_r = '0;
`endif
                end
                m_run = 1'b1; m_pos = 0; m_fs = 1'b1;
            end else if (m_run && m_pos == 31) begin
                m_run = 1'b0; m_pos = 0;
            end else if (m_run) begin
                m_pos++;
            end
            if (acc) hq.push_back({sl, sr});
        end
    end

    // Compare every cycle against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            logic e_d, e_lr, e_rdy;
            e_d   = m_run ? (m_pos < 16 ? m_l[15-m_pos] : m_r[31-m_pos]) : 1'b0;
            e_lr  = m_run && (((m_pos + 1) % 32) >= 16);
            e_rdy = (hq.size() == 0) || at_boundary();
            chk("data", 64'(data), 64'(e_d));
            chk("lrck", 64'(lrck), 64'(e_lr));
            chk("frame_start", 64'(fs), 64'(m_fs));
            chk("underrun", 64'(ur), 64'(m_ur));
            chk("ready", 64'(ready), 64'(e_rdy));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (fs) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_fs: no FRAME_START within 100 cycles at %0t", $time);
        end
    endtask

    task automatic capture(output logic [31:0] d, output logic [31:0] lr, output logic u);
        bit ok;
        d = '0; lr = '0; u = 1'b0;
        wait_fs(ok);
        if (ok) begin
            u  = ur;
            d  = {31'd0, data};
            lr = {31'd0, lrck};
            for (int i = 1; i < 32; i++) begin
                step(1);
                d  = {d[30:0], data};
                lr = {lr[30:0], lrck};
            end
        end
    endtask

    logic [31:0] cd, clr;
    logic        cu;
    logic [31:0] pr [4] = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h1234_5678};
    int          acc_cyc [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #3;
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_lrck", 64'(lrck), 64'd0);
        chk("rst_fs", 64'(fs), 64'd0);
        chk("rst_ur", 64'(ur), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        step(2);
        rst_n = 1'b1;

        // 1. Prefill in IDLE, then enable
        valid = 1'b1; sl = 16'h8001; sr = 16'h7FFE;
        step(1);
        valid = 1'b0; en = 1'b1;
        capture(cd, clr, cu);
        chk("t1_data", 64'(cd), 64'h8001_7FFE);
        chk("t1_lrck", 64'(clr), 64'h0001_FFFE);
        chk("t1_ur", 64'(cu), 64'd0);

        // 2. Stream four pairs with VALID held high
        step(1);
        begin
            int idx, rp, urc;
            bit acc;
            idx = 0; rp = 0; urc = 0;
            valid = 1'b1; {sl, sr} = pr[0];
            for (int c = 0; c < 200 && idx < 4; c++) begin
                @(negedge clk);
                acc = ready;
                if (idx >= 1) begin
                    if (ready) rp++;
                    if (ur) urc++;
                end
                @(posedge clk);
                #1;
                if (acc) begin
                    acc_cyc[idx] = c;
                    idx++;
                    if (idx < 4) {sl, sr} = pr[idx];
                    else valid = 1'b0;
                end
            end
            chk("t2_accepts", 64'(idx), 64'd4);
            chk("t2_ready_pulses", 64'(rp), 64'd3);
            chk("t2_underruns", 64'(urc), 64'd0);
            chk("t2_gap_a", 64'(acc_cyc[2] - acc_cyc[1]), 64'd32);
            chk("t2_gap_b", 64'(acc_cyc[3] - acc_cyc[2]), 64'd32);
        end

        // 3. Last pair A, then starvation
        capture(cd, clr, cu);
        chk("t3_a_data", 64'(cd), 64'h1234_5678);
        chk("t3_a_ur", 64'(cu), 64'd0);
        capture(cd, clr, cu);
        chk("t3_ur", 64'(cu), 64'd1);
`ifdef DAC_TX_HOLD_ON_UNDERRUN_EN
        chk("t3_ur_data", 64'(cd), 64'h1234_5678);
`else
        chk("t3_ur_data", 64'(cd), 64'd0);
`endif

        // 4. Drop ENABLE mid-frame with a pair queued
        begin
            bit ok;
            wait_fs(ok);
        end
        valid = 1'b1; sl = 16'hAAAA; sr = 16'h5555;
        step(1);
        valid = 1'b0;
        step(4);
        en = 1'b0;
        step(26);
        chk("t4_last_fs", 64'(fs), 64'd0);
        step(1);
        chk("t4_idle_data", 64'(data), 64'd0);
        chk("t4_idle_lrck", 64'(lrck), 64'd0);
        chk("t4_idle_ready", 64'(ready), 64'd0);
        step(5);
        chk("t4_held_ready", 64'(ready), 64'd0);
        en = 1'b1;
        capture(cd, clr, cu);
        chk("t4_b_data", 64'(cd), 64'hAAAA_5555);
        chk("t4_b_ur", 64'(cu), 64'd0);

        // 5. Asynchronous reset at k=20
        valid = 1'b1; sl = 16'hFFFF; sr = 16'hFFFF;
        step(1);
        valid = 1'b0;
        begin
            bit ok;
            wait_fs(ok);
        end
        valid = 1'b1; sl = 16'h0F0F; sr = 16'hF0F0;
        step(1);
        valid = 1'b0;
        step(19);
        chk("t5_pre_data", 64'(data), 64'd1);
        chk("t5_pre_lrck", 64'(lrck), 64'd1);
        #2;
        rst_n = 1'b0; en = 1'b0;
        #1;
        chk("t5_rst_data", 64'(data), 64'd0);
        chk("t5_rst_lrck", 64'(lrck), 64'd0);
        chk("t5_rst_fs", 64'(fs), 64'd0);
        chk("t5_rst_ur", 64'(ur), 64'd0);
        chk("t5_rst_ready", 64'(ready), 64'd0);
        step(2);
        rst_n = 1'b1;
        #1;
        chk("t5_post_ready", 64'(ready), 64'd1);
        step(3);
        chk("t5_post_data", 64'(data), 64'd0);
        en = 1'b1;
        capture(cd, clr, cu);
        chk("t5_after_ur", 64'(cu), 64'd1);
        chk("t5_after_data", 64'(cd), 64'd0);

        // 6. Left-justified, 24-bit slots, 16-bit samples
        v6 = 1'b1; l6 = 16'hABCD; r6 = 16'h1234;
        step(1);
        v6 = 1'b0; en6 = 1'b1;
        begin
            logic [47:0] d48, lr48;
            logic        u6;
            bit          ok;
            d48 = '0; lr48 = '0; u6 = 1'b0; ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                step(1);
                if (fs6) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("t6_fs_seen", 64'(ok), 64'd1);
            u6   = ur6;
            d48  = {47'd0, d6};
            lr48 = {47'd0, lr6};
            for (int i = 1; i < 48; i++) begin
                step(1);
                d48  = {d48[46:0], d6};
                lr48 = {lr48[46:0], lr6};
            end
            chk("t6_data", 64'(d48), 64'hABCD_0012_3400);
            chk("t6_lrck", 64'(lr48), 64'h0000_00FF_FFFF);
            chk("t6_ur", 64'(u6), 64'd0);
        end
        en6 = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
